pwm_deadtime: RTL and testbench
===============================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0010, register block base address.
REQ-002 SHALL have parameter DT_RESET, default 16'd4, reset value of the dead-time register.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports add/din  input  32 each  bus address / write data.
REQ-006 SHALL have port dout  output  32  read data.
REQ-007 SHALL have ports wr, rd, wr_strobe, rd_strobe  input  1 each  bus request / completion strobes.
REQ-008 SHALL have ports wr_busy, rd_busy  output  1 each  transaction-in-progress flags.
REQ-009 SHALL have port mask  input  4  write byte enables, bit n = din[8n+7:8n].
REQ-010 SHALL have port pwm_in  input  1  raw PWM from the upstream PWM generator.
REQ-011 SHALL have port fault_n  input  1  asynchronous external fault, active-low.
REQ-012 SHALL have ports pwm_hi, pwm_lo  output  1 each  complementary high-side/low-side gate drives.

Function
REQ-013 Registers SHALL be:
- BASE+0x0 DT: [15:0] dead-time cycles, R/W, upper bits read 0.
- BASE+0x4 CTRL: [0] enable, [1] invert hi, [2] invert lo, R/W; [3] fault clear, write-1 pulse, reads 0.
- BASE+0x8 STATUS: read-only; [0] fault latched, [3:1] FSM state code; writes ignored.
REQ-014 Bus FSM SHALL have states IDLE, WR_WAIT, RD_WAIT; wr wins if wr and rd are both high in IDLE.
REQ-015 IDLE with wr and a mapped address SHALL latch add/din/mask and go to WR_WAIT; wr_busy SHALL be 1 throughout WR_WAIT.
REQ-016 In WR_WAIT with wr_strobe=1, the latched data SHALL be written under mask at that edge, and the FSM SHALL return to IDLE.
REQ-017 IDLE with rd and a mapped address SHALL load dout with the register value at that edge and go to RD_WAIT; rd_busy SHALL be 1 throughout RD_WAIT.
REQ-018 In RD_WAIT with rd_strobe=1, the FSM SHALL return to IDLE; dout SHALL hold its value until the next read.
REQ-019 Unmapped addresses SHALL be ignored, with no busy assertion.
REQ-020 Output FSM SHALL have states SAFE, LO_ON, DT_RISE, HI_ON, DT_FALL, encoded 0..4; a 16-bit counter cnt SHALL be cleared on entry to DT_RISE/DT_FALL and increment in those states.
REQ-021 Transitions (pwm_in sampled each edge):
- LO_ON: pwm_in=1 -> DT_RISE.
- DT_RISE: pwm_in=0 -> LO_ON (pulse swallowed); cnt==DT-1 -> HI_ON.
- HI_ON: pwm_in=0 -> DT_FALL.
- DT_FALL: pwm_in=1 -> HI_ON; cnt==DT-1 -> LO_ON.
REQ-022 DT=0 SHALL bypass the DT states (LO_ON<->HI_ON directly).
REQ-023 enable=0 in any state SHALL force SAFE next edge; SAFE with enable=1 SHALL go to DT_RISE if pwm_in=1, else DT_FALL.
REQ-024 Drive outputs:
- raw hi = (state==HI_ON), raw lo = (state==LO_ON).
- pwm_hi = raw hi XOR CTRL[1]; pwm_lo = raw lo XOR CTRL[2].
- Both raw outputs SHALL never be 1 simultaneously.
REQ-025 Latency: the active output SHALL turn off 1 edge after a pwm_in change; the opposite output SHALL turn on DT+1 edges after the change.
REQ-026 A DT write during a DT state SHALL take effect on the compare in the next cycle; if cnt already >= new DT-1, the transition SHALL occur on the next edge.

Reset
REQ-027 rst=0 SHALL immediately force:
- state=SAFE, bus FSM=IDLE, cnt=0.
- DT=DT_RESET, CTRL=0, fault latch=0.
- dout=0, wr_busy=0, rd_busy=0, pwm_hi=0, pwm_lo=0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no register update.

Configuration
REQ-029 With macro PWM_DEADTIME_FAULT_EN defined:
- fault_n SHALL pass a 2-flop synchronizer; synchronized low SHALL force SAFE and set STATUS[0].
- SAFE SHALL be held until CTRL[3] is written 1 while synchronized fault_n=1.
REQ-030 Without PWM_DEADTIME_FAULT_EN, fault_n SHALL be ignored and STATUS[0] SHALL read 0.

Verification
REQ-031 Reset, read BASE+0x0 -> dout=0x0000_0004; read BASE+0x4 -> 0; pwm_hi=pwm_lo=0.
REQ-032 DT=4, enable=1, pwm_in 0->1 held 20 cycles -> pwm_lo falls 1 edge later, pwm_hi rises 5 edges after the pwm_in edge; no overlap.
REQ-033 DT=8, pwm_in pulse high for 3 cycles -> pwm_hi never asserts, pwm_lo returns after the pulse.
REQ-034 DT=0, pwm_in toggling every 2 cycles -> outputs complementary, 1-edge latency, no gap.
REQ-035 Write CTRL=0x7 with mask=4'b0001, then read CTRL -> 0x0000_0007; pwm_hi/pwm_lo idle levels inverted (both 1 in SAFE).
REQ-036 With PWM_DEADTIME_FAULT_EN: fault_n low 1 cycle during HI_ON -> SAFE within 3 edges, STATUS=0x1; write CTRL[3]=1 -> resumes via DT_RISE/DT_FALL.

Source files
------------

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate drive with dead-time insertion behind a strobed register bus.
// Define PWM_DEADTIME_FAULT_EN to add the synchronized, latched external fault shutdown.
module pwm_deadtime #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter logic [15:0] DT_RESET  = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] add,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        wr,
    input  logic        rd,
    input  logic        wr_strobe,
    input  logic        rd_strobe,
    output logic        wr_busy,
    output logic        rd_busy,
    input  logic [3:0]  mask,
    input  logic        pwm_in,
    input  logic        fault_n,
    output logic        pwm_hi,
    output logic        pwm_lo
);
    localparam logic [1:0] B_IDLE = 2'd0, B_WR = 2'd1, B_RD = 2'd2;
    localparam logic [2:0] S_SAFE = 3'd0, S_LO = 3'd1, S_DTR = 3'd2, S_HI = 3'd3, S_DTF = 3'd4;

    logic [1:0]  bus_q, bus_d, sel_q, sel_d, wmask_q;
    logic [15:0] wdat_q, dt_q, dt_d, cnt_q, cnt_d;
    logic [2:0]  ctrl_q, ctrl_d, st_q, st_d;
    logic [31:0] dout_q, rdata;
    logic        fault_q, fault_d, hit, do_wr, clr, halt, dt_z, dt_done, in_dt_d, in_dt_q;
    logic        unused_ok;

    assign sel_d = add == BASE_ADDR + 32'd4 ? 2'd1 : add == BASE_ADDR + 32'd8 ? 2'd2 : 2'd0;
    assign hit   = add == BASE_ADDR || sel_d != 2'd0;
    assign rdata = sel_d == 2'd0 ? {16'd0, dt_q} : sel_d == 2'd1 ? {29'd0, ctrl_q} : {28'd0, st_q, fault_q};
    assign do_wr = bus_q == B_WR && wr_strobe;
    assign dt_d[15:8] = do_wr && sel_q == 2'd0 && wmask_q[1] ? wdat_q[15:8] : dt_q[15:8];
    assign dt_d[7:0]  = do_wr && sel_q == 2'd0 && wmask_q[0] ? wdat_q[7:0] : dt_q[7:0];
    assign ctrl_d = do_wr && sel_q == 2'd1 && wmask_q[0] ? wdat_q[2:0] : ctrl_q;
    assign clr    = do_wr && sel_q == 2'd1 && wmask_q[0] && wdat_q[3];
    assign bus_d  = bus_q == B_IDLE ? (wr ? (hit ? B_WR : B_IDLE) : (rd && hit ? B_RD : B_IDLE))
                  : bus_q == B_WR ? (wr_strobe ? B_IDLE : B_WR)
                  : bus_q == B_RD ? (rd_strobe ? B_IDLE : B_RD) : B_IDLE;
    assign unused_ok = ^{din[31:16], mask[3:2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q   <= B_IDLE;
            sel_q   <= 2'd0;
            wmask_q <= 2'd0;
            wdat_q  <= 16'd0;
            dt_q    <= DT_RESET;
            ctrl_q  <= 3'd0;
            dout_q  <= 32'd0;
        end else begin
            bus_q  <= bus_d;
            dt_q   <= dt_d;
            ctrl_q <= ctrl_d;
            if (bus_q == B_IDLE && wr && hit) begin
                sel_q   <= sel_d;
                wdat_q  <= din[15:0];
                wmask_q <= mask[1:0];
            end
            if (bus_q == B_IDLE && !wr && rd && hit)
                dout_q <= rdata;
        end
    end

    // 17-bit compare so a DT of 0 (or a DT shrunk below cnt) ends the dead time at once
    assign dt_z    = dt_q == 16'd0;
    assign dt_done = {1'b0, cnt_q} + 17'd1 >= {1'b0, dt_q};
    assign in_dt_d = st_d == S_DTR || st_d == S_DTF;
    assign in_dt_q = st_q == S_DTR || st_q == S_DTF;
    assign cnt_d   = in_dt_d && st_d != st_q ? 16'd0 : in_dt_q ? cnt_q + 16'd1 : cnt_q;

    always_comb begin
        st_d = st_q;
        case (st_q)
            S_SAFE:  st_d = pwm_in ? (dt_z ? S_HI : S_DTR) : (dt_z ? S_LO : S_DTF);
            S_LO:    st_d = pwm_in ? (dt_z ? S_HI : S_DTR) : S_LO;
            S_DTR:   st_d = !pwm_in ? S_LO : dt_done ? S_HI : S_DTR;
            S_HI:    st_d = !pwm_in ? (dt_z ? S_LO : S_DTF) : S_HI;
            S_DTF:   st_d = pwm_in ? S_HI : dt_done ? S_LO : S_DTF;
            default: st_d = S_SAFE;
        endcase
        if (!ctrl_q[0] || halt)
            st_d = S_SAFE;
    end

`ifdef PWM_DEADTIME_FAULT_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sync_q <= 2'b11;
        else
            sync_q <= {sync_q[0], fault_n};
    end
    assign halt    = !sync_q[1] || fault_q;
    assign fault_d = !sync_q[1] || (fault_q && !clr);
`else
    logic unused_fault;
    assign unused_fault = ^{fault_n, clr};
    assign halt    = 1'b0;
    assign fault_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= S_SAFE;
            cnt_q   <= 16'd0;
            fault_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign pwm_hi  = (st_q == S_HI) ^ ctrl_q[1];
    assign pwm_lo  = (st_q == S_LO) ^ ctrl_q[2];
    assign dout    = dout_q;
    assign wr_busy = bus_q == B_WR;
    assign rd_busy = bus_q == B_RD;
endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: scoreboard bench for pwm_deadtime register bus and gate-drive timing.
module tb_pwm_deadtime;
    localparam logic [31:0] BASE = 32'h4000_0010;

    logic        clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, wr_strobe = 1'b0, rd_strobe = 1'b0;
    logic        pwm_in = 1'b0, fault_n = 1'b1;
    logic [31:0] add = 32'd0, din = 32'd0, dout;
    logic [3:0]  mask = 4'd0;
    logic        wr_busy, rd_busy, pwm_hi, pwm_lo;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] rd_q[$], pwm_q[$];

    always #5 clk = ~clk;

    pwm_deadtime dut (
        .clk(clk), .rst(rst), .add(add), .din(din), .dout(dout),
        .wr(wr), .rd(rd), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .mask(mask),
        .pwm_in(pwm_in), .fault_n(fault_n), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        add = a; din = d; mask = m; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("wr_busy", {31'd0, wr_busy}, 32'd1);
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        check("wr_done", {31'd0, wr_busy}, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
        add = a; rd = 1'b1;
        rd_q.push_back(e);
        @(negedge clk);
        rd = 1'b0;
        check("rd_busy", {31'd0, rd_busy}, 32'd1);
        check("rd_data", dout, rd_q.pop_front());
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        check("rd_done", {31'd0, rd_busy}, 32'd0);
        check("rd_hold", dout, e);
    endtask

    // drive pwm_in for one edge; expectation is {hi, lo}
    task automatic step(input logic p, input logic [1:0] e);
        pwm_in = p;
        pwm_q.push_back({30'd0, e});
        @(negedge clk);
        check("pwm", {30'd0, pwm_hi, pwm_lo}, pwm_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_busy", {30'd0, wr_busy, rd_busy}, 32'd0);
        check("rst_pwm", {30'd0, pwm_hi, pwm_lo}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_read(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h8, 32'h0);
        bus_read(BASE, 32'h4);
        add = BASE + 32'hC; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("unmapped_rd_busy", {31'd0, rd_busy}, 32'd0);
        check("unmapped_rd_dout", dout, 32'h4);
        add = BASE + 32'h100; din = 32'hFF; mask = 4'hF; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("unmapped_wr_busy", {31'd0, wr_busy}, 32'd0);
        add = BASE; din = 32'h55; mask = 4'hF; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; wr_strobe = 1'b1; rst = 1'b0;
        #1 check("rst_abort_busy", {31'd0, wr_busy}, 32'd0);
        @(negedge clk);
        wr_strobe = 1'b0; rst = 1'b1;
        bus_read(BASE, 32'h4);

        bus_write(BASE + 32'h4, 32'h1, 4'hF);
        repeat (4) step(1'b0, 2'b00);
        repeat (3) step(1'b0, 2'b01);
        bus_read(BASE + 32'h8, 32'h2);
        for (int j = 0; j < 20; j++) step(1'b1, j >= 4 ? 2'b10 : 2'b00);
        for (int j = 0; j < 10; j++) step(1'b0, j >= 4 ? 2'b01 : 2'b00);

        bus_write(BASE, 32'h8, 4'b0011);
        repeat (3) step(1'b1, 2'b00);
        repeat (10) step(1'b0, 2'b01);

        bus_write(BASE, 32'd10, 4'b0011);
        add = BASE; din = 32'h1; mask = 4'b0011; wr = 1'b1;
        step(1'b1, 2'b00);
        wr = 1'b0; wr_strobe = 1'b1;
        step(1'b1, 2'b00);
        wr_strobe = 1'b0;
        repeat (3) step(1'b1, 2'b10);
        step(1'b0, 2'b00);
        repeat (3) step(1'b0, 2'b01);

        bus_write(BASE, 32'h0, 4'b0011);
        for (int j = 0; j < 16; j++) step(((j / 2) % 2) == 0, ((j / 2) % 2) == 0 ? 2'b10 : 2'b01);

        bus_write(BASE, 32'h0000_1234, 4'b0010);
        bus_read(BASE, 32'h1200);
        bus_write(BASE, 32'hFFFF_0004, 4'b1101);
        bus_read(BASE, 32'h1204);
        bus_write(BASE, 32'h4, 4'b0011);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE, 32'h4);
        bus_read(BASE + 32'h4, 32'h1);

        bus_write(BASE + 32'h4, 32'h7, 4'b0001);
        bus_read(BASE + 32'h4, 32'h7);
        step(1'b0, 2'b10);
        bus_write(BASE + 32'h4, 32'h6, 4'b0001);
        repeat (2) step(1'b0, 2'b11);
        bus_write(BASE + 32'h4, 32'h0, 4'b0000);
        bus_read(BASE + 32'h4, 32'h6);
        bus_write(BASE + 32'h4, 32'hF, 4'b0001);
        repeat (4) step(1'b0, 2'b11);
        step(1'b0, 2'b10);
        bus_read(BASE + 32'h4, 32'h7);
        bus_write(BASE + 32'h4, 32'h1, 4'b0001);
        step(1'b0, 2'b01);

        repeat (4) step(1'b1, 2'b00);
        step(1'b1, 2'b10);
`ifdef PWM_DEADTIME_FAULT_EN
        fault_n = 1'b0;
        step(1'b1, 2'b10);
        fault_n = 1'b1;
        step(1'b1, 2'b10);
        repeat (4) step(1'b1, 2'b00);
        bus_read(BASE + 32'h8, 32'h1);
        bus_write(BASE + 32'h4, 32'h9, 4'b0001);
        repeat (4) step(1'b1, 2'b00);
        step(1'b1, 2'b10);
        bus_read(BASE + 32'h8, 32'h6);
`else
        fault_n = 1'b0;
        step(1'b1, 2'b10);
        fault_n = 1'b1;
        repeat (5) step(1'b1, 2'b10);
        bus_read(BASE + 32'h8, 32'h6);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
